// File: rtl/tl_burst_arbiter_pkg.sv
// Shared types and helpers for the TileLink A-channel burst arbiter.
// Beat counting turns a_size into the number of data beats a request occupies.
package tl_burst_arbiter_pkg;

  typedef enum logic {ArbIdle, ArbLocked} arb_state_e;

  // Only data-carrying requests larger than one beat span multiple beats.
  function automatic int unsigned tl_burst_beats(input int unsigned size,
                                                 input logic        has_data,
                                                 input int unsigned beat_bytes_log);
    if (has_data && (size > beat_bytes_log)) begin
      return 32'd1 << (size - beat_bytes_log);
    end
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_burst_arbiter_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping past the top link back to link 0.
module tl_rr_picker #(
  parameter int  NumLinks  = 4,
  localparam int LinkWidth = (NumLinks > 1) ? $clog2(NumLinks) : 1
) (
  input  logic [NumLinks-1:0]  req_i,
  input  logic [LinkWidth-1:0] ptr_i,
  output logic [NumLinks-1:0]  onehot_o,
  output logic [LinkWidth-1:0] idx_o,
  output logic                 any_o
);

  logic [LinkWidth-1:0] w_pos;

  // Scan from the farthest candidate down so the last hit is the closest to ptr_i.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    w_pos    = '0;
    for (int i = NumLinks - 1; i >= 0; i--) begin
      w_pos = LinkWidth'((int'(ptr_i) + i) % NumLinks);
      if (req_i[w_pos]) begin
        onehot_o        = '0;
        onehot_o[w_pos] = 1'b1;
        idx_o           = w_pos;
        any_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_burst_arbiter.sv
// Round-robin A-channel arbiter that locks the grant for every beat of a
// multi-beat burst and advances fairness only when the burst completes.
module tl_burst_arbiter
  import tl_burst_arbiter_pkg::*;
#(
  parameter int  NumLinks  = 4,
  parameter int  DataWidth = 64,
  parameter int  SizeWidth = 3,
  parameter int  MaxSize   = 6,
  localparam int LinkWidth = (NumLinks > 1) ? $clog2(NumLinks) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumLinks-1:0]           req_valid_i,
  input  logic [NumLinks*SizeWidth-1:0] req_size_i,
  input  logic [NumLinks-1:0]           req_has_data_i,
  output logic [NumLinks-1:0]           req_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NumLinks-1:0]           gnt_o,
  output logic [LinkWidth-1:0]          gnt_idx_o,
  output logic                          locked_o
);

  localparam int BeatBytesLog = $clog2(DataWidth / 8);
  localparam int CntW         = MaxSize - BeatBytesLog + 1;

  function automatic logic [LinkWidth-1:0] next_ptr(input logic [LinkWidth-1:0] idx);
    return LinkWidth'((int'(idx) + 1) % NumLinks);
  endfunction

  arb_state_e           r_state, w_state_nxt;
  logic [LinkWidth-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [LinkWidth-1:0] r_lock_idx, w_lock_idx_nxt;
  logic [CntW-1:0]      r_beat_cnt, w_beat_cnt_nxt;

  logic [NumLinks-1:0]  w_pick_onehot;
  logic [LinkWidth-1:0] w_pick_idx;
  logic                 w_pick_any;
  logic [SizeWidth-1:0] w_win_size;
  logic                 w_win_has_data;
  int unsigned          w_win_beats;

  logic [NumLinks-1:0]  w_gnt, w_req_ready;
  logic [LinkWidth-1:0] w_gnt_idx;
  logic                 w_out_valid, w_locked, w_fire;

  tl_rr_picker #(.NumLinks(NumLinks)) u_picker (
    .req_i    (req_valid_i),
    .ptr_i    (r_rr_ptr),
    .onehot_o (w_pick_onehot),
    .idx_o    (w_pick_idx),
    .any_o    (w_pick_any)
  );

  assign w_win_size     = req_size_i[w_pick_idx*SizeWidth +: SizeWidth];
  assign w_win_has_data = req_has_data_i[w_pick_idx];
  assign w_win_beats    = tl_burst_beats(int'(w_win_size), w_win_has_data, BeatBytesLog);
  assign w_fire         = w_out_valid && out_ready_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_lock_idx_nxt = r_lock_idx;
    w_beat_cnt_nxt = r_beat_cnt;
    w_gnt          = '0;
    w_gnt_idx      = '0;
    w_out_valid    = 1'b0;
    w_req_ready    = '0;
    w_locked       = 1'b0;
    case (r_state)
      ArbIdle: begin
        w_gnt       = w_pick_onehot;
        w_gnt_idx   = w_pick_idx;
        w_out_valid = w_pick_any;
        if (w_pick_any) begin
          w_req_ready[w_pick_idx] = out_ready_i;
        end
        if (w_fire) begin
          if (w_win_beats == 32'd1) begin
            w_rr_ptr_nxt = next_ptr(w_pick_idx);
          end else begin
            w_state_nxt    = ArbLocked;
            w_lock_idx_nxt = w_pick_idx;
            w_beat_cnt_nxt = CntW'(w_win_beats - 32'd1);
          end
        end
      end
      ArbLocked: begin
        // Only the owner's valid matters; other links wait until the burst ends.
        w_gnt[r_lock_idx]       = 1'b1;
        w_gnt_idx               = r_lock_idx;
        w_out_valid             = req_valid_i[r_lock_idx];
        w_req_ready[r_lock_idx] = out_ready_i;
        w_locked                = 1'b1;
        if (w_fire) begin
          w_beat_cnt_nxt = r_beat_cnt - CntW'(1);
          if (r_beat_cnt == CntW'(1)) begin
            w_state_nxt  = ArbIdle;
            w_rr_ptr_nxt = next_ptr(r_lock_idx);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ArbIdle;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Outputs are held quiet for the whole reset window, not just after the edge.
  assign gnt_o       = rst_ni ? w_gnt       : '0;
  assign gnt_idx_o   = rst_ni ? w_gnt_idx   : '0;
  assign out_valid_o = rst_ni ? w_out_valid : 1'b0;
  assign req_ready_o = rst_ni ? w_req_ready : '0;
  assign locked_o    = rst_ni ? w_locked    : 1'b0;

  a_first_beat_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ArbIdle && w_fire) |-> (int'(w_win_size) <= MaxSize));

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));

  a_cnt_iff_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((r_beat_cnt != '0) == (r_state == ArbLocked)));

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Bench for tl_burst_arbiter: directed scenarios plus random traffic, each
// cycle compared against a transaction-level round-robin/burst model.
module tb_tl_burst_arbiter;

  localparam int N  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*SW-1:0] req_size = '0;
  logic [N-1:0]  req_has_data = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_idx;
  logic          locked;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: next round-robin start, owner of the open burst, beats still owed.
  int m_ptr = 0;
  int m_owner = 0;
  int m_left = 0;

  logic [N-1:0] obs_gnt;
  logic         obs_locked, obs_valid;
  logic [N-1:0] obs_ready;

  always #5 clk = ~clk;

  tl_burst_arbiter #(.NumLinks(N), .DataWidth(64), .SizeWidth(SW), .MaxSize(6)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_size_i     (req_size),
    .req_has_data_i (req_has_data),
    .req_ready_o    (req_ready),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .gnt_o          (gnt),
    .gnt_idx_o      (gnt_idx),
    .locked_o       (locked)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beats_of(input int size, input bit hd);
    return (hd && size > 3) ? (1 << (size - 3)) : 1;
  endfunction

  // Drive one cycle of inputs, compare against the model, then advance both.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] hd,
                      input logic [N*SW-1:0] sz, input bit rdy, input bit rst);
    int win;
    logic [N-1:0] e_gnt, e_ready;
    int e_idx;
    bit e_valid, e_locked, fire;
    @(negedge clk);
    req_valid = v; req_has_data = hd; req_size = sz; out_ready = rdy; rst_n = rst;
    #1;
    win = -1; e_gnt = '0; e_ready = '0; e_idx = 0; e_valid = 0; e_locked = 0;
    if (rst) begin
      if (m_left == 0) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        if (win >= 0) begin
          e_gnt[win] = 1'b1; e_idx = win; e_valid = 1; e_ready[win] = rdy;
        end
      end else begin
        e_gnt[m_owner] = 1'b1; e_idx = m_owner; e_valid = v[m_owner];
        e_ready[m_owner] = rdy; e_locked = 1;
      end
    end
    check_val("gnt", int'(gnt), int'(e_gnt));
    check_val("gnt_idx", int'(gnt_idx), e_idx);
    check_val("out_valid", int'(out_valid), int'(e_valid));
    check_val("req_ready", int'(req_ready), int'(e_ready));
    check_val("locked", int'(locked), int'(e_locked));
    obs_gnt = gnt; obs_locked = locked; obs_valid = out_valid; obs_ready = req_ready;
    fire = e_valid && rdy;
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0; m_left = 0; m_owner = 0;
    end else if (fire) begin
      if (m_left == 0) begin
        int b;
        b = beats_of(int'(sz[win*SW +: SW]), hd[win]);
        if (b == 1) m_ptr = (win + 1) % N;
        else begin m_owner = win; m_left = b - 1; end
      end else begin
        m_left--;
        if (m_left == 0) m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  initial begin
    logic [N*SW-1:0] rsz;
    // Reset: outputs must be quiet even with requests pending.
    step(4'b1111, 4'b0000, 12'h6DB, 1, 0);
    check_val("rst_gnt", int'(obs_gnt), 0);
    step(4'b0000, 4'b0000, 12'h000, 1, 0);

    // 1: four single-beat Gets rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, 12'h6DB, 1, 1);
      check_val("s1_rr", int'(obs_gnt), 1 << (i % 4));
    end

    // 2: move pointer to link 2, then an 8-beat PutFull on link 2 with link 1 waiting.
    step(4'b0010, 4'b0000, 12'h018, 1, 1);
    for (int b = 0; b < 8; b++) begin
      step(4'b0110, 4'b0100, 12'h198, 1, 1);
      check_val("s2_gnt", int'(obs_gnt), 4'b0100);
      check_val("s2_lock", int'(obs_locked), (b == 0) ? 0 : 1);
    end
    step(4'b0110, 4'b0100, 12'h198, 1, 1);
    check_val("s2_after", int'(obs_gnt), 4'b0010);

    // 3: pointer to 0 via link 3, then 4-beat burst on link 0 with a 3-cycle stall.
    step(4'b1000, 4'b0000, 12'h600, 1, 1);
    for (int c = 0; c < 7; c++) begin
      step((c >= 2 && c < 5) ? 4'b1000 : 4'b1001, 4'b0001, 12'h605, 1, 1);
      check_val("s3_gnt", int'(obs_gnt), 4'b0001);
      check_val("s3_valid", int'(obs_valid), (c >= 2 && c < 5) ? 0 : 1);
    end
    step(4'b1000, 4'b0000, 12'h605, 1, 1);
    check_val("s3_link3", int'(obs_gnt), 4'b1000);

    // 4: device stall with link 1 pending; grant holds and pointer does not move.
    for (int c = 0; c < 5; c++) begin
      step(4'b0010, 4'b0000, 12'h018, 0, 1);
      check_val("s4_gnt", int'(obs_gnt), 4'b0010);
      check_val("s4_rdy", int'(obs_ready), 0);
    end
    step(4'b0010, 4'b0000, 12'h018, 1, 1);
    check_val("s4_fire", int'(obs_ready), 4'b0010);
    step(4'b0110, 4'b0000, 12'h0D8, 1, 1);
    check_val("s4_next", int'(obs_gnt), 4'b0100);

    // 5: Get of size 6 on link 3 is one beat; pointer wraps to 0.
    step(4'b1000, 4'b0000, 12'hC00, 1, 1);
    check_val("s5_lock", int'(obs_locked), 0);
    step(4'b1111, 4'b0000, 12'h6DB, 1, 1);
    check_val("s5_wrap", int'(obs_gnt), 4'b0001);

    // 6: reset during beat 4 of an 8-beat burst on link 1.
    for (int c = 0; c < 3; c++) step(4'b0011, 4'b0010, 12'h033, 1, 1);
    step(4'b0011, 4'b0010, 12'h033, 1, 0);
    check_val("s6_rst", int'(obs_gnt), 0);
    step(4'b0011, 4'b0010, 12'h033, 1, 1);
    check_val("s6_gnt", int'(obs_gnt), 4'b0001);
    check_val("s6_lock", int'(obs_locked), 0);

    // Random traffic with occasional stalls and rare resets.
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < N; l++) rsz[l*SW +: SW] = SW'($urandom_range(0, 6));
      step(N'($urandom), N'($urandom), rsz, ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
